gamma_lcg_gen: RTL and testbench

Gamma (keystream) generator for the gamma coder. It produces one 8-bit gamma byte per handshake from a linear congruential recurrence, x(n+1) = (A_MULT·x(n) + C_INC) mod 256. It sits directly upstream of the 8-bit carry-lookahead adder and drives its b0..b7 inputs, while plaintext drives a0..a7. The coder keeps q0..q7 as the mod-256 ciphertext and ignores q8.

---
 rtl/gamma_lcg_gen_if.sv | 38 +++
 rtl/gamma_lcg_gen.sv | 83 ++++++++
 tb/tb_gamma_lcg_gen.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/gamma_lcg_gen_if.sv
// -----------------------------------------------------------------------------
// gamma_lcg_gen_if
// Control and stream bundle between the gamma generator and its user.
//
// Signals:
//   seed_i        [7:0]  seed value, sampled while seed_load_i is high
//   seed_load_i          one-cycle request: load seed and start generating
//   halt_i               one-cycle request: stop generating
//   gamma_ready_i        consumer accepts a gamma byte this cycle
//   gamma_o       [7:0]  current gamma byte (LCG state); bit 0 drives b0
//   gamma_valid_o        gamma_o is valid
//   cnt_o         [7:0]  bytes transferred since the last seed load, mod 256
//   wrap_o               one-cycle pulse after cnt_o wraps 255 -> 0
//
// Modports:
//   master : the user side (drives seed/load/halt/ready, observes the stream)
//   slave  : the generator side
// -----------------------------------------------------------------------------
interface gamma_lcg_gen_if;
  logic [7:0] seed_i;
  logic       seed_load_i;
  logic       halt_i;
  logic       gamma_ready_i;
  logic [7:0] gamma_o;
  logic       gamma_valid_o;
  logic [7:0] cnt_o;
  logic       wrap_o;

  modport master (
    output seed_i, seed_load_i, halt_i, gamma_ready_i,
    input  gamma_o, gamma_valid_o, cnt_o, wrap_o
  );

  modport slave (
    input  seed_i, seed_load_i, halt_i, gamma_ready_i,
    output gamma_o, gamma_valid_o, cnt_o, wrap_o
  );
endinterface

// File: rtl/gamma_lcg_gen.sv
// -----------------------------------------------------------------------------
// gamma_lcg_gen
// Keystream (gamma) generator for the gamma coder. Emits one byte per
// valid/ready handshake from x(n+1) = (A_MULT*x(n) + C_INC) mod 256. The byte
// feeds the b inputs of the downstream 8-bit adder.
//
// Parameters:
//   A_MULT : LCG multiplier (A_MULT mod 4 = 1 for full period)
//   C_INC  : LCG increment  (odd for full period)
//
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : synchronous, active-high reset
//   bus : gamma_lcg_gen_if.slave (seed/load/halt/ready in, gamma/valid/cnt/wrap out)
// -----------------------------------------------------------------------------
module gamma_lcg_gen #(
  parameter logic [7:0] A_MULT = 8'd5,
  parameter logic [7:0] C_INC  = 8'd3
) (
  input  logic           clk,
  input  logic           rst,
  gamma_lcg_gen_if.slave bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t     r_state;
  logic [7:0] r_gamma;
  logic [7:0] r_cnt;
  logic       r_wrap;

  logic        w_xfer;
  logic [15:0] w_prod;
  logic [7:0]  w_next;

  // A byte moves only while we are presenting valid data.
  assign w_xfer = (r_state == ST_RUN) && bus.gamma_ready_i;

  // Full 16-bit product; only the low byte survives the mod-256 reduction,
  // matching the carry-discarding adder downstream.
  assign w_prod = {8'd0, A_MULT} * {8'd0, r_gamma};
  assign w_next = 8'(w_prod + {8'd0, C_INC});

  // Priority: rst > seed_load_i > halt_i > transfer. A transfer coinciding
  // with halt_i still completes; one coinciding with seed_load_i is dropped.
  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order in this block.
    if (rst) begin
      r_state <= ST_IDLE;
      r_gamma <= 8'h00;
      r_cnt   <= 8'h00;
      r_wrap  <= 1'b0;
    end else if (bus.seed_load_i) begin
      r_state <= ST_RUN;
      r_gamma <= bus.seed_i;
      r_cnt   <= 8'h00;
      r_wrap  <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_gamma <= w_next;
        r_cnt   <= r_cnt + 8'd1;
        r_wrap  <= (r_cnt == 8'hFF);
      end else begin
        r_wrap  <= 1'b0;
      end
      // Only reseeding leaves IDLE, so halt in IDLE is harmless.
      if (bus.halt_i) begin
        r_state <= ST_IDLE;
      end
    end
  end

  // Outputs come straight from flops; valid is the decoded one-bit state.
  assign bus.gamma_o       = r_gamma;
  assign bus.gamma_valid_o = (r_state == ST_RUN);
  assign bus.cnt_o         = r_cnt;
  assign bus.wrap_o        = r_wrap;

endmodule

// File: tb/tb_gamma_lcg_gen.sv
// -----------------------------------------------------------------------------
// tb_gamma_lcg_gen
// Self-checking bench for gamma_lcg_gen. The reference model keeps only the
// seed, the number of transfers since that seed and a run flag; the expected
// gamma byte is recomputed by iterating the recurrence from the seed.
// -----------------------------------------------------------------------------
module tb_gamma_lcg_gen;

  localparam logic [7:0] A_MULT = 8'd5;
  localparam logic [7:0] C_INC  = 8'd3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  gamma_lcg_gen_if bus ();

  gamma_lcg_gen #(
    .A_MULT (A_MULT),
    .C_INC  (C_INC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  bit m_run;
  int m_seed;
  int m_n;
  bit m_wrap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Gamma byte after n steps of the recurrence starting from seed.
  function automatic logic [7:0] lcg_n(input int seed, input int n);
    int x;
    int a;
    int c;
    x = seed;
    a = int'(A_MULT);
    c = int'(C_INC);
    for (int i = 0; i < n; i++) x = (a * x + c) % 256;
    return 8'(x);
  endfunction

  // Drive one cycle of inputs, clock it, advance the model, compare outputs.
  task automatic step(input bit r, input bit sl, input logic [7:0] sd,
                      input bit h, input bit rdy);
    bit xfer;
    rst               = r;
    bus.seed_load_i   = sl;
    bus.seed_i        = sd;
    bus.halt_i        = h;
    bus.gamma_ready_i = rdy;
    @(posedge clk);
    xfer = m_run && rdy;
    if (r) begin
      m_run = 0; m_seed = 0; m_n = 0; m_wrap = 0;
    end else if (sl) begin
      m_run = 1; m_seed = int'(sd); m_n = 0; m_wrap = 0;
    end else begin
      if (xfer) begin
        m_n++;
        m_wrap = (m_n % 256 == 0);
      end else begin
        m_wrap = 0;
      end
      if (h) m_run = 0;
    end
    #1;
    check("gamma", 32'(bus.gamma_o),       32'(lcg_n(m_seed, m_n)));
    check("valid", 32'(bus.gamma_valid_o), 32'(m_run));
    check("cnt",   32'(bus.cnt_o),         32'(m_n % 256));
    check("wrap",  32'(bus.wrap_o),        32'(m_wrap));
  endtask

  logic [7:0] basic_seq [6] = '{8'h00, 8'h03, 8'h12, 8'h5D, 8'hD4, 8'h27};
  logic [7:0] plain     [3] = '{8'h10, 8'h20, 8'h30};
  logic [7:0] cipher    [3] = '{8'h10, 8'h23, 8'h42};

  initial begin
    bit         seen [256];
    int         distinct;
    int         wraps;
    logic [8:0] q;

    m_run = 0; m_seed = 0; m_n = 0; m_wrap = 0;
    rst = 1'b1;
    bus.seed_i = 8'h00; bus.seed_load_i = 1'b0;
    bus.halt_i = 1'b0;  bus.gamma_ready_i = 1'b0;

    // Reset wins over a concurrent seed load.
    step(1, 1, 8'h3C, 0, 1);
    step(1, 1, 8'h3C, 0, 1);
    check("rst_gamma", 32'(bus.gamma_o), 32'h00);
    check("rst_valid", 32'(bus.gamma_valid_o), 32'h0);
    check("rst_cnt",   32'(bus.cnt_o), 32'h00);
    check("rst_wrap",  32'(bus.wrap_o), 32'h0);

    // Basic sequence from seed 0x00.
    step(0, 1, 8'h00, 0, 1);
    check("basic_valid_rise", 32'(bus.gamma_valid_o), 32'h1);
    check("basic_g0", 32'(bus.gamma_o), 32'(basic_seq[0]));
    for (int i = 1; i < 6; i++) begin
      step(0, 0, 8'h00, 0, 1);
      check("basic_seq", 32'(bus.gamma_o), 32'(basic_seq[i]));
      check("basic_cnt", 32'(bus.cnt_o), 32'(i));
    end

    // Backpressure from seed 0xFF.
    step(0, 1, 8'hFF, 0, 0);
    check("bp_seed", 32'(bus.gamma_o), 32'hFF);
    step(0, 0, 8'h00, 0, 1);
    check("bp_fe", 32'(bus.gamma_o), 32'hFE);
    step(0, 0, 8'h00, 0, 0);
    check("bp_hold1", 32'(bus.gamma_o), 32'hFE);
    step(0, 0, 8'h00, 0, 0);
    check("bp_hold2", 32'(bus.gamma_o), 32'hFE);
    check("bp_cnt_hold", 32'(bus.cnt_o), 32'd1);
    step(0, 0, 8'h00, 0, 1);
    check("bp_f9", 32'(bus.gamma_o), 32'hF9);
    check("bp_cnt", 32'(bus.cnt_o), 32'd2);

    // Halt with a concurrent transfer: the byte counts, then freeze.
    step(0, 0, 8'h00, 1, 1);
    check("halt_gamma", 32'(bus.gamma_o), 32'hE0);
    check("halt_cnt",   32'(bus.cnt_o), 32'd3);
    check("halt_valid", 32'(bus.gamma_valid_o), 32'h0);
    step(0, 0, 8'h00, 0, 1);
    check("halt_frozen", 32'(bus.gamma_o), 32'hE0);
    check("halt_frozen_cnt", 32'(bus.cnt_o), 32'd3);

    // Full period from seed 0xA5.
    step(0, 1, 8'hA5, 0, 1);
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    distinct = 0;
    wraps    = 0;
    for (int i = 0; i < 256; i++) begin
      step(0, 0, 8'h00, 0, 1);
      if (!seen[bus.gamma_o]) distinct++;
      seen[bus.gamma_o] = 1'b1;
      if (bus.wrap_o) wraps++;
    end
    check("period_distinct", 32'(distinct), 32'd256);
    check("period_return",   32'(bus.gamma_o), 32'hA5);
    check("period_cnt",      32'(bus.cnt_o), 32'd0);
    check("period_wrap_now", 32'(bus.wrap_o), 32'h1);
    check("period_wraps",    32'(wraps), 32'd1);
    step(0, 0, 8'h00, 0, 0);
    check("period_wrap_drop", 32'(bus.wrap_o), 32'h0);

    // Seed load with halt and a transfer in the same cycle.
    step(0, 0, 8'h00, 0, 1);
    step(0, 1, 8'h77, 1, 1);
    check("sim_seed_gamma", 32'(bus.gamma_o), 32'h77);
    check("sim_seed_valid", 32'(bus.gamma_valid_o), 32'h1);
    check("sim_seed_cnt",   32'(bus.cnt_o), 32'd0);
    step(0, 0, 8'h00, 0, 1);
    // Reset mid-stream together with a seed load.
    step(1, 1, 8'h55, 0, 1);
    check("sim_rst_gamma", 32'(bus.gamma_o), 32'h00);
    check("sim_rst_valid", 32'(bus.gamma_valid_o), 32'h0);
    check("sim_rst_cnt",   32'(bus.cnt_o), 32'd0);

    // End-to-end through a behavioural 8-bit adder: q = plaintext + gamma.
    step(0, 1, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) begin
      q = {1'b0, plain[i]} + {1'b0, bus.gamma_o};
      check("e2e_q", 32'(q[7:0]), 32'(cipher[i]));
      check("e2e_q8", 32'(q[8]), 32'h0);
      step(0, 0, 8'h00, 0, 1);
    end

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 29) == 0),
           8'($urandom),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
